// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU/register-file datapath and its sequencing
// controller: widths, ALU opcodes, controller states.
package ALU_REGFILE_Defs;

  localparam int unsigned REGFILE_WIDTH       = 8;
  localparam int unsigned REGFILE_ADDR_WIDTH  = 3;
  localparam int unsigned ALU_OUTPUT_WIDTH    = REGFILE_WIDTH + 1;
  localparam int unsigned COUNT_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } ctrl_state_t;

  // Load immediates are reported on the wider ALU result bus.
  function automatic logic [ALU_OUTPUT_WIDTH-1:0] zext_imm(
    input logic [REGFILE_WIDTH-1:0] imm
  );
    return ALU_OUTPUT_WIDTH'(imm);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external ALU + register file datapath.
// Accepts one command at a time (ALU op or immediate load), drives the
// datapath read/execute/writeback steps and returns the result through a
// valid/ready response channel. Counts completed responses (saturating).
module alu_seq_ctrl
  import ALU_REGFILE_Defs::*;
#(
  parameter int unsigned COUNT_WIDTH  = COUNT_WIDTH_DEFAULT,
  parameter bit          WRITEBACK_EN = 1'b1
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Cmd_Valid,
  output logic                          Cmd_Ready,
  input  logic                          Cmd_Load,
  input  aluop_t                        Cmd_Opcode,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Cmd_Src1,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Cmd_Src2,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Cmd_Dst,
  input  logic [REGFILE_WIDTH-1:0]      Cmd_Imm,
  input  logic                          Cmd_Carry_In,
  output logic                          Rsp_Valid,
  input  logic                          Rsp_Ready,
  output logic [ALU_OUTPUT_WIDTH-1:0]   Rsp_Result,
  output logic [COUNT_WIDTH-1:0]        Op_Count,
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
  output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
  output logic                          Write_enable,
  output logic [REGFILE_WIDTH-1:0]      Write_data,
  output logic                          Carry_In,
  output aluop_t                        Opcode,
  input  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out
);

  ctrl_state_t                   state, state_next;
  logic                          load_q;
  aluop_t                        op_q;
  logic [REGFILE_ADDR_WIDTH-1:0] src1_q, src2_q, dst_q;
  logic [REGFILE_WIDTH-1:0]      imm_q;
  logic                          cin_q;
  logic [ALU_OUTPUT_WIDTH-1:0]   result_q;
  logic [COUNT_WIDTH-1:0]        count_q;

  logic cmd_accept;
  logic rsp_accept;

  assign cmd_accept = (state == IDLE) && Cmd_Valid;
  assign rsp_accept = (state == RESP) && Rsp_Ready;

  // State register; async reset aborts any in-flight command.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Capture the whole command on the accept handshake.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      load_q <= 1'b0;
      op_q   <= ALU_ADD;
      src1_q <= '0;
      src2_q <= '0;
      dst_q  <= '0;
      imm_q  <= '0;
      cin_q  <= 1'b0;
    end else if (cmd_accept) begin
      load_q <= Cmd_Load;
      op_q   <= Cmd_Opcode;
      src1_q <= Cmd_Src1;
      src2_q <= Cmd_Src2;
      dst_q  <= Cmd_Dst;
      imm_q  <= Cmd_Imm;
      cin_q  <= Cmd_Carry_In;
    end
  end

  // Result register: immediate on load accept, ALU output leaving EXEC.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                  result_q <= '0;
    else if (cmd_accept && Cmd_Load) result_q <= zext_imm(Cmd_Imm);
    else if (state == EXEC)        result_q <= ALU_Out;
  end

  // Completed-response counter, saturating at all-ones.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                         count_q <= '0;
    else if (rsp_accept && count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
  end

  // Next-state and datapath/handshake outputs; everything idles at zero.
  always_comb begin
    state_next   = state;
    Cmd_Ready    = 1'b0;
    Rsp_Valid    = 1'b0;
    Read_Addr_1  = '0;
    Read_Addr_2  = '0;
    Write_Addr   = '0;
    Write_enable = 1'b0;
    Write_data   = '0;
    Carry_In     = 1'b0;
    Opcode       = ALU_ADD;
    case (state)
      IDLE: begin
        Cmd_Ready = 1'b1;
        if (Cmd_Valid) state_next = Cmd_Load ? WB : EXEC;
      end
      EXEC: begin
        Read_Addr_1 = src1_q;
        Read_Addr_2 = src2_q;
        Opcode      = op_q;
        Carry_In    = cin_q;
        state_next  = WB;
      end
      WB: begin
        Write_Addr   = dst_q;
        Write_data   = load_q ? imm_q : result_q[REGFILE_WIDTH-1:0];
        Write_enable = load_q | WRITEBACK_EN;
        state_next   = RESP;
      end
      RESP: begin
        Rsp_Valid = 1'b1;
        if (Rsp_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Rsp_Result = result_q;
  assign Op_Count   = count_q;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of completed-operation counter.
REQ-002 SHALL have parameter WRITEBACK_EN, default 1: 1 = ALU results written to Cmd_Dst; 0 = ALU results returned only.
REQ-003 SHALL have port Clock, input, 1: system clock; all state on rising edge.
REQ-004 SHALL have port Reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port Cmd_Valid, input, 1: command present.
REQ-006 SHALL have port Cmd_Ready, output, 1: controller can accept a command.
REQ-007 SHALL have port Cmd_Load, input, 1: 1 = write Cmd_Imm to Cmd_Dst (no ALU op); 0 = ALU op.
REQ-008 SHALL have port Cmd_Opcode, input, aluop_t: ALU operation.
REQ-009 SHALL have ports Cmd_Src1, Cmd_Src2, Cmd_Dst, input, REGFILE_ADDR_WIDTH: source and destination registers.
REQ-010 SHALL have port Cmd_Imm, input, REGFILE_WIDTH: load immediate.
REQ-011 SHALL have port Cmd_Carry_In, input, 1: ALU carry in.
REQ-012 SHALL have port Rsp_Valid, output, 1: result available.
REQ-013 SHALL have port Rsp_Ready, input, 1: consumer accepts result.
REQ-014 SHALL have port Rsp_Result, output, ALU_OUTPUT_WIDTH: ALU result, or zero-extended immediate for loads.
REQ-015 SHALL have port Op_Count, output, COUNT_WIDTH: completed responses.
REQ-016 SHALL have ports Read_Addr_1, Read_Addr_2, Write_Addr, output, REGFILE_ADDR_WIDTH: drive the alu_regfile datapath.
REQ-017 SHALL have ports Write_enable, output, 1; Write_data, output, REGFILE_WIDTH; Carry_In, output, 1; Opcode, output, aluop_t: drive the datapath.
REQ-018 SHALL have port ALU_Out, input, ALU_OUTPUT_WIDTH: datapath result.

Function
REQ-019 SHALL implement FSM states IDLE, EXEC, WB, RESP; Cmd_Ready = 1 only in IDLE.
REQ-020 Handshake on Cmd_Valid && Cmd_Ready at edge T SHALL register all Cmd_* fields.
REQ-021 ALU command SHALL go IDLE -> EXEC (T+1) -> WB (T+2) -> RESP (T+3).
REQ-022 Load command SHALL go IDLE -> WB (T+1) -> RESP (T+2).
REQ-023 In EXEC, outputs SHALL drive Read_Addr_1/2 = Src1/Src2, Opcode, Carry_In from registered command; ALU_Out SHALL be captured into the result register at the EXEC->WB edge.
REQ-024 In WB, Write_enable SHALL be 1 for exactly one cycle, Write_Addr = Dst, Write_data = result[REGFILE_WIDTH-1:0] (ALU) or Imm (load).
REQ-025 If WRITEBACK_EN = 0, Write_enable SHALL stay 0 in WB for ALU commands; loads SHALL still write.
REQ-026 In RESP, Rsp_Valid SHALL be 1 and Rsp_Result constant until Rsp_Ready; on handshake, next state SHALL be IDLE.
REQ-027 Op_Count SHALL increment by 1 on each response handshake and saturate at all-ones (no wrap).
REQ-028 Cmd_Dst equal to Cmd_Src1 or Cmd_Src2 SHALL be legal; the read uses pre-write value.
REQ-029 Cmd_Valid in non-IDLE states SHALL be ignored (not accepted, no side effect).
REQ-030 Write_enable SHALL be 0 in every state except WB.

Reset
REQ-031 Reset_n low SHALL immediately force IDLE, Cmd_Ready 1 after reset release, Rsp_Valid 0, Write_enable 0, Op_Count 0, Rsp_Result 0, all address/data/Opcode/Carry_In outputs 0.
REQ-032 Reset mid-operation SHALL abort it with no register write and no response.

Structure
REQ-033 State enum type (ctrl_state_t) and COUNT_WIDTH default SHALL be added to ALU_REGFILE_Defs alongside aluop_t and width constants.
REQ-034 Block SHALL be a single module; top-level pairing with alu_regfile SHALL be done in a wrapper alu_seq_top, not inside this module.

Verification (8-bit registers, 9-bit ALU_Out)
REQ-035 Load r1=0x0F, load r2=0xF1 -> each Rsp_Result 0x00F/0x0F1 two cycles after accept, Write_enable pulse one cycle, Op_Count=2.
REQ-036 ADD r1,r2->r3, Carry 0 -> Rsp_Valid at T+3, Rsp_Result 0x100, r3 = 0x00.
REQ-037 Rsp_Ready held 0 for 5 cycles -> Rsp_Valid and Rsp_Result stable, Cmd_Ready 0, second Cmd_Valid ignored.
REQ-038 ADD r3,r3->r3 with r3=0x40 -> Rsp_Result 0x080, r3 = 0x80.
REQ-039 Reset_n low during WB -> Write_enable drops same cycle, destination register unchanged, Op_Count 0.
REQ-040 COUNT_WIDTH=2, 5 operations -> Op_Count 3 after third and stays 3.
